// File: rtl/rj_pkg.sv
// Shared constants for the multi-channel rj table bank: default geometry,
// load-state encoding and a constant-foldable clog2.
package rj_pkg;

  localparam int RJ_WIDTH  = 16;
  localparam int RJ_DEPTH  = 16;
  localparam int RJ_NUM_CH = 2;

  // Load FSM encoding, kept as plain 2-bit constants for legacy tooling.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  // Ceiling log2, clamped to 1 so a width derived from it is never zero.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rj_load_ctrl.sv
// Load sequencer for the rj bank: IDLE/LOAD/READY state machine and the
// auto-incrementing write pointer that walks channel-major through all tables.
module rj_load_ctrl
  import rj_pkg::*;
#(
  parameter int DEPTH  = RJ_DEPTH,
  parameter int NUM_CH = RJ_NUM_CH,
  parameter int CH_W   = 1,
  parameter int ENT_W  = clog2(RJ_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start_i,
  input  logic             wr_valid_i,
  output logic             wr_en_o,
  output logic [CH_W-1:0]  wr_ch_o,
  output logic [ENT_W-1:0] wr_ent_o,
  output logic             wr_ready_o,
  output logic             load_done_o
);

  localparam int TOTAL = NUM_CH * DEPTH;
  localparam int PTR_W = clog2(TOTAL);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TOTAL - 1);

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [31:0]      ptr_ext;
  logic             wr_en;

  // Next-state logic; loadStart overrides everything, including a write
  // offered in the same cycle, so that word is dropped and ptr restarts.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    if (load_start_i) begin
      state_d = ST_LOAD;
      ptr_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE:  ;
        ST_LOAD: begin
          if (wr_valid_i) begin
            wr_en = 1'b1;
            // The last word is written this cycle; ptr parks rather than wraps.
            if (ptr_q == PTR_LAST) state_d = ST_READY;
            else                   ptr_d   = ptr_q + 1'b1;
          end
        end
        ST_READY: ;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State and pointer registers; async reset abandons any partial load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Split the flat pointer into channel and entry (channel-major order).
  always_comb begin
    ptr_ext  = 32'(ptr_q);
    wr_ch_o  = CH_W'(ptr_ext / DEPTH);
    wr_ent_o = ENT_W'(ptr_ext % DEPTH);
  end

  assign wr_en_o     = wr_en;
  assign wr_ready_o  = (state_q == ST_LOAD);
  assign load_done_o = (state_q == ST_READY);

endmodule

// File: rtl/rj_mem_bank.sv
// NUM_CH independent rj tables loaded through a valid/ready stream and read
// through a one-cycle registered port with range and load-state checking.
module rj_mem_bank
  import rj_pkg::*;
#(
  parameter int WIDTH  = RJ_WIDTH,
  parameter int DEPTH  = RJ_DEPTH,
  parameter int NUM_CH = RJ_NUM_CH,
  parameter int ADDR_W = 5,
  parameter int CH_W   = 1
) (
  input  logic              Sclk,
  input  logic              Reset,
  input  logic              loadStart,
  input  logic              wrValid,
  input  logic [WIDTH-1:0]  wrData,
  output logic              wrReady,
  output logic              loadDone,
  input  logic              rdEn,
  input  logic [CH_W-1:0]   rdChannel,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [WIDTH-1:0]  rdData,
  output logic              rdValid,
  output logic              rdErr
);

  localparam int ENT_W = clog2(DEPTH);

  logic                          wr_en;
  logic [CH_W-1:0]               wr_ch;
  logic [ENT_W-1:0]              wr_ent;
  logic                          load_done;
  logic [NUM_CH-1:0][WIDTH-1:0]  ch_rd_word;
  logic [ENT_W-1:0]              rd_ent;
  logic                          rd_ok;
  logic [WIDTH-1:0]              rd_word;
  logic                          rd_valid_q;
  logic                          rd_err_q;
  logic [WIDTH-1:0]              rd_data_q;

  rj_load_ctrl #(
    .DEPTH  (DEPTH),
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .ENT_W  (ENT_W)
  ) u_load_ctrl (
    .clk          (Sclk),
    .rst          (Reset),
    .load_start_i (loadStart),
    .wr_valid_i   (wrValid),
    .wr_en_o      (wr_en),
    .wr_ch_o      (wr_ch),
    .wr_ent_o     (wr_ent),
    .wr_ready_o   (wrReady),
    .load_done_o  (load_done)
  );

  assign rd_ent = rdAddr[ENT_W-1:0];

  // One table per channel; storage is deliberately not reset.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] tbl_q [DEPTH];

    // Write the word the sequencer has steered to this channel.
    always_ff @(posedge Sclk) begin
      if (wr_en && (wr_ch == CH_W'(c))) tbl_q[wr_ent] <= wrData;
    end

    assign ch_rd_word[c] = tbl_q[rd_ent];
  end

  // A read is legal only once loaded and with channel/entry in range; the
  // load state is sampled at issue, so a read racing LOAD->READY is rejected.
  always_comb begin
    rd_ok   = load_done
            && (32'(rdAddr)    < DEPTH)
            && (32'(rdChannel) < NUM_CH);
    rd_word = rd_ok ? ch_rd_word[rdChannel] : '0;
  end

  // Registered read result; idle cycles drive zeros rather than stale data.
  always_ff @(posedge Sclk or posedge Reset) begin
    if (Reset) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rdEn;
      rd_err_q   <= rdEn && !rd_ok;
      rd_data_q  <= rdEn ? rd_word : '0;
    end
  end

  assign loadDone = load_done;
  assign rdValid  = rd_valid_q;
  assign rdErr    = rd_err_q;
  assign rdData   = rd_data_q;

endmodule
